// File: rtl/echo_fb.sv
// echo_fb: single-tap feedback echo on a 10-bit offset-binary ADC stream.
// Each accepted sample walks IDLE->READ->CALC->WRITE against an 8192-word history of y.
module echo_fb (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [9:0] data_in,
    input  logic [8:0] delay,
    input  logic [1:0] gain_sel,
    output logic [9:0] data_out,
    output logic       out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CALC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [9:0]         mem_r [0:8191];
    logic [12:0]        wr_ptr_r;
    logic [12:0]        fill_r;
    logic [12:0]        dist_r;
    logic [9:0]         sample_r;
    logic [1:0]         gain_r;
    logic [9:0]         rd_data_r;
    logic [9:0]         y_r;
    logic [12:0]        rd_addr_s;
    logic               echo_ok_s;
    logic signed [11:0] echo_s;
    logic signed [11:0] x_s;
    logic signed [11:0] prod_s;
    logic signed [11:0] scaled_s;
    logic signed [11:0] sum_s;
    logic [9:0]         y_s;

    function automatic logic [9:0] sat10(input logic signed [11:0] v);
        logic [9:0] r;
        if (v > 12'sd511) begin
            r = 10'h1FF;
        end else if (v < -12'sd512) begin
            r = 10'h200;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    // Echo path: history words are masked until enough samples exist to cover the delay.
    always_comb begin
        rd_addr_s = wr_ptr_r - dist_r;
        echo_ok_s = (dist_r != 13'd0) && (fill_r >= dist_r);
        if (echo_ok_s) begin
            echo_s = {{2{rd_data_r[9]}}, rd_data_r};
        end else begin
            echo_s = 12'sd0;
        end
        x_s      = $signed({2'b00, sample_r}) - 12'sd512;
        prod_s   = echo_s * $signed({10'd0, gain_r});
        scaled_s = prod_s >>> 2;
        sum_s    = x_s + scaled_s;
        y_s      = sat10(sum_s);
    end

    // Next-state logic: one state per clock, only IDLE waits for a strobe.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_valid) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ:    state_next_s = CALC;
            CALC:    state_next_s = WRITE;
            WRITE:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture, result, pointer/fill bookkeeping and registered outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_r  <= 13'd0;
            fill_r    <= 13'd0;
            dist_r    <= 13'd0;
            sample_r  <= 10'd512;
            gain_r    <= 2'd0;
            y_r       <= 10'd0;
            data_out  <= 10'd512;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (data_valid) begin
                        sample_r <= data_in;
                        gain_r   <= gain_sel;
                        dist_r   <= {delay, 4'd0};
                    end
                end
                CALC: begin
                    y_r <= y_s;
                end
                WRITE: begin
                    data_out  <= {~y_r[9], y_r[8:0]};
                    out_valid <= 1'b1;
                    wr_ptr_r  <= wr_ptr_r + 13'd1;
                    if (fill_r != 13'h1FFF) begin
                        fill_r <= fill_r + 13'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // History RAM: synchronous read in READ; the write is suppressed by a reset landing in WRITE.
    always_ff @(posedge sysclk) begin
        if (state_r == READ) begin
            rd_data_r <= mem_r[rd_addr_s];
        end
        if (!reset && (state_r == WRITE)) begin
            mem_r[wr_ptr_r] <= y_r;
        end
    end

endmodule

// File: tb/tb_echo_fb.sv
// Directed bench for echo_fb: hand-computed echo sequences, clipping, wrap and reset aborts.
module tb_echo_fb;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       data_valid = 1'b0;
    logic [9:0] data_in = 10'd512;
    logic [8:0] delay = 9'd0;
    logic [1:0] gain_sel = 2'd0;
    logic [9:0] data_out;
    logic       out_valid;

    int checks = 0;
    int failures = 0;

    always #10 sysclk = ~sysclk;

    echo_fb dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .data_valid (data_valid),
        .data_in    (data_in),
        .delay      (delay),
        .gain_sel   (gain_sel),
        .data_out   (data_out),
        .out_valid  (out_valid)
    );

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        data_valid = 1'b0;
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    // One strobe; edges = rising edges after the capture edge until out_valid (0 = timeout).
    task automatic send(input logic [9:0] din, output logic [9:0] dout, output int edges);
        @(negedge sysclk);
        data_in = din;
        data_valid = 1'b1;
        @(posedge sysclk);
        #1;
        data_valid = 1'b0;
        edges = 0;
        dout = 10'd0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge sysclk);
            #1;
            if (out_valid) begin
                edges = k;
                dout = data_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        do_reset();
        checks++;
        if (data_out !== 10'd512) begin
            failures++;
            $display("FAIL reset_data_out got=%0d want=512", data_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        @(negedge sysclk);
        reset = 1'b1;
        data_valid = 1'b1;
        data_in = 10'd900;
        @(negedge sysclk);
        reset = 1'b0;
        data_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge sysclk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_priority out_valid_pulses=%0d want=0", seen);
        end
        checks++;
        if (data_out !== 10'd512) begin
            failures++;
            $display("FAIL reset_priority_data_out got=%0d want=512", data_out);
        end
    endtask

    task automatic test_zero_signal();
        logic [8:0] dl [5] = '{9'd0, 9'd1, 9'd3, 9'd511, 9'd7};
        logic [1:0] gs [5] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd3};
        logic [9:0] dout;
        int edges;
        for (int i = 0; i < 5; i++) begin
            delay = dl[i];
            gain_sel = gs[i];
            for (int j = 0; j < 4; j++) begin
                send(10'd512, dout, edges);
                checks++;
                if (edges !== 3) begin
                    failures++;
                    $display("FAIL zero_latency cfg=%0d edges=%0d want=3", i, edges);
                end
                checks++;
                if (dout !== 10'd512) begin
                    failures++;
                    $display("FAIL zero_data cfg=%0d got=%0d want=512", i, dout);
                end
            end
        end
    endtask

    task automatic test_gain0_ignore();
        int cnt;
        int first;
        logic [9:0] val;
        cnt = 0;
        first = 0;
        val = 10'd0;
        @(negedge sysclk);
        delay = 9'd5;
        gain_sel = 2'd0;
        data_in = 10'd700;
        data_valid = 1'b1;
        @(posedge sysclk);
        #1;
        data_valid = 1'b0;
        @(posedge sysclk);
        #1;
        data_valid = 1'b1;
        data_in = 10'd100;
        @(posedge sysclk);
        #1;
        data_valid = 1'b0;
        for (int k = 3; k <= 10; k++) begin
            @(posedge sysclk);
            #1;
            if (out_valid) begin
                cnt++;
                if (first == 0) first = k;
                val = data_out;
            end
        end
        checks++;
        if (cnt !== 1) begin
            failures++;
            $display("FAIL ignore_pulses got=%0d want=1", cnt);
        end
        checks++;
        if (first !== 3) begin
            failures++;
            $display("FAIL ignore_latency got=%0d want=3", first);
        end
        checks++;
        if (val !== 10'd700) begin
            failures++;
            $display("FAIL gain0_data got=%0d want=700", val);
        end
    endtask

    task automatic test_impulse();
        logic [9:0] dout;
        logic [9:0] exp;
        int edges;
        do_reset();
        delay = 9'd1;
        gain_sel = 2'd2;
        for (int n = 0; n <= 48; n++) begin
            case (n)
                0:       exp = 10'd768;
                16:      exp = 10'd640;
                32:      exp = 10'd576;
                48:      exp = 10'd544;
                default: exp = 10'd512;
            endcase
            send((n == 0) ? 10'd768 : 10'd512, dout, edges);
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL impulse n=%0d got=%0d want=%0d edges=%0d", n, dout, exp, edges);
            end
        end
    endtask

    task automatic test_clip();
        logic [9:0] dout;
        int edges;
        do_reset();
        delay = 9'd1;
        gain_sel = 2'd3;
        for (int n = 0; n < 32; n++) begin
            send(10'd1023, dout, edges);
            checks++;
            if (dout !== 10'd1023) begin
                failures++;
                $display("FAIL clip_high n=%0d got=%0d want=1023", n, dout);
            end
        end
        do_reset();
        for (int n = 0; n < 32; n++) begin
            send(10'd0, dout, edges);
            checks++;
            if (dout !== 10'd0) begin
                failures++;
                $display("FAIL clip_low n=%0d got=%0d want=0", n, dout);
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] dout;
        int edges;
        do_reset();
        delay = 9'd511;
        gain_sel = 2'd2;
        for (int n = 0; n <= 8200; n++) begin
            send(10'd512, dout, edges);
            checks++;
            if (dout !== 10'd512) begin
                failures++;
                $display("FAIL wrap_pre n=%0d got=%0d want=512", n, dout);
            end
        end
        send(10'd768, dout, edges);
        checks++;
        if (dout !== 10'd768) begin
            failures++;
            $display("FAIL wrap_impulse got=%0d want=768", dout);
        end
        for (int m = 1; m < 8176; m++) begin
            send(10'd512, dout, edges);
            checks++;
            if (dout !== 10'd512) begin
                failures++;
                $display("FAIL wrap_mid m=%0d got=%0d want=512", m, dout);
            end
        end
        send(10'd512, dout, edges);
        checks++;
        if (dout !== 10'd640) begin
            failures++;
            $display("FAIL wrap_echo got=%0d want=640", dout);
        end
    endtask

    task automatic test_reset_calc();
        logic [9:0] dout;
        logic [9:0] exp;
        int edges;
        int seen;
        delay = 9'd1;
        gain_sel = 2'd0;
        send(10'd700, dout, edges);
        checks++;
        if (dout !== 10'd700) begin
            failures++;
            $display("FAIL rcalc_pre got=%0d want=700", dout);
        end
        gain_sel = 2'd2;
        @(negedge sysclk);
        data_in = 10'd768;
        data_valid = 1'b1;
        @(posedge sysclk);
        #1;
        data_valid = 1'b0;
        @(posedge sysclk);
        #1;
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge sysclk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rcalc_pulses got=%0d want=0", seen);
        end
        checks++;
        if (data_out !== 10'd512) begin
            failures++;
            $display("FAIL rcalc_data_out got=%0d want=512", data_out);
        end
        for (int n = 0; n <= 16; n++) begin
            exp = (n == 0) ? 10'd768 : ((n == 16) ? 10'd640 : 10'd512);
            send((n == 0) ? 10'd768 : 10'd512, dout, edges);
            checks++;
            if (dout !== exp) begin
                failures++;
                $display("FAIL rcalc_refill n=%0d got=%0d want=%0d", n, dout, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_signal();
        test_gain0_ignore();
        test_impulse();
        test_clip();
        test_wrap();
        test_reset_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
